// File: rtl/serial_src_pkg.sv
// Shared types and helpers for the serial pattern source.
// State encoding, counter width and word-length rule.
package serial_src_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_SHIFT
  } state_e;

  localparam int WORD_CNT_W = 16;

  // Requested length 0 or above the word width means a full word.
  function automatic int unsigned eff_len(
    input int unsigned len,
    input int unsigned width
  );
    if (len == 0 || len > width) begin
      return width;
    end
    return len;
  endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in/serial-out register with a registered serial bit.
// Idle cycles drive the fill bit so the line rests at IDLE_BIT.
module piso_shift_reg #(
  parameter int W         = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0,
  parameter int LENW      = 4
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            load_en,
  input  logic            shift_en,
  input  logic [W-1:0]    load_data,
  input  logic [LENW-1:0] load_len,
  output logic            ser_out
);

  logic [W-1:0]    sr_q;
  logic [W-1:0]    sr_d;
  logic [W-1:0]    aligned;
  logic [LENW-1:0] shamt;
  logic            out_q;
  logic            out_d;

  // Align the word so its first bit sits at the exit end, then step.
  always_comb begin
    shamt   = LENW'(W) - load_len;
    aligned = MSB_FIRST ? (load_data << shamt) : load_data;
    sr_d    = sr_q;
    out_d   = IDLE_BIT;
    if (load_en) begin
      if (MSB_FIRST) begin
        out_d = aligned[W-1];
        sr_d  = {aligned[W-2:0], IDLE_BIT};
      end else begin
        out_d = aligned[0];
        sr_d  = {IDLE_BIT, aligned[W-1:1]};
      end
    end else if (shift_en) begin
      if (MSB_FIRST) begin
        out_d = sr_q[W-1];
        sr_d  = {sr_q[W-2:0], IDLE_BIT};
      end else begin
        out_d = sr_q[0];
        sr_d  = {IDLE_BIT, sr_q[W-1:1]};
      end
    end
  end

  // Shift register and output bit; clear wins over any load.
  always_ff @(posedge clk) begin
    if (clr) begin
      sr_q  <= '0;
      out_q <= IDLE_BIT;
    end else begin
      sr_q  <= sr_d;
      out_q <= out_d;
    end
  end

  assign ser_out = out_q;

endmodule

// File: rtl/serial_pattern_source.sv
// Serial bit-stream source feeding a sequence detector.
// FSM, bit counter, repeat buffer and completed-word counter.
module serial_pattern_source
  import serial_src_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0,
  parameter int LW        = $clog2(WIDTH + 1) + 1
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [WIDTH-1:0]      load_data,
  input  logic [LW-1:0]         load_len,
  input  logic                  repeat_en,
  output logic                  ser_out,
  output logic                  ser_valid,
  output logic                  word_done,
  output logic [WORD_CNT_W-1:0] word_count
);

  localparam int RW = $clog2(WIDTH + 1);

  state_e                state_q;
  state_e                state_d;
  logic [RW-1:0]         rem_q;
  logic [RW-1:0]         rem_d;
  logic [RW-1:0]         len_q;
  logic [RW-1:0]         len_d;
  logic [WIDTH-1:0]      word_q;
  logic [WIDTH-1:0]      word_d;
  logic                  ser_valid_q;
  logic                  ser_valid_d;
  logic                  word_done_q;
  logic                  word_done_d;
  logic [WORD_CNT_W-1:0] word_cnt_q;
  logic [WORD_CNT_W-1:0] word_cnt_d;

  logic [RW-1:0]         le;
  logic [RW-1:0]         ld_len;
  logic [WIDTH-1:0]      ld_word;
  logic                  last;
  logic                  accept;
  logic                  rpt;
  logic                  start;
  logic                  shift_en;

  // Next state: a new load beats a repeat, which beats going idle.
  always_comb begin
    le         = RW'(eff_len(32'(load_len), WIDTH));
    last       = (state_q == ST_SHIFT) && (rem_q == RW'(1));
    load_ready = (state_q == ST_IDLE) || last;
    accept     = load_valid && load_ready;
    rpt        = last && !accept && repeat_en;
    start      = accept || rpt;
    shift_en   = (state_q == ST_SHIFT) && !last;
    ld_word    = accept ? load_data : word_q;
    ld_len     = accept ? le : len_q;

    state_d     = state_q;
    rem_d       = rem_q;
    len_d       = len_q;
    word_d      = word_q;
    ser_valid_d = 1'b0;
    word_done_d = 1'b0;
    word_cnt_d  = word_cnt_q + WORD_CNT_W'(last);

    unique case (1'b1)
      start: begin
        state_d     = ST_SHIFT;
        rem_d       = ld_len;
        len_d       = ld_len;
        word_d      = ld_word;
        ser_valid_d = 1'b1;
        word_done_d = (ld_len == RW'(1));
      end
      shift_en: begin
        rem_d       = rem_q - RW'(1);
        ser_valid_d = 1'b1;
        word_done_d = (rem_q == RW'(2));
      end
      default: begin
        state_d = ST_IDLE;
        rem_d   = '0;
      end
    endcase
  end

  // Control registers; clear aborts any word in flight.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= ST_IDLE;
      rem_q       <= '0;
      len_q       <= '0;
      word_q      <= '0;
      ser_valid_q <= 1'b0;
      word_done_q <= 1'b0;
      word_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      len_q       <= len_d;
      word_q      <= word_d;
      ser_valid_q <= ser_valid_d;
      word_done_q <= word_done_d;
      word_cnt_q  <= word_cnt_d;
    end
  end

  piso_shift_reg #(
    .W        (WIDTH),
    .MSB_FIRST(MSB_FIRST),
    .IDLE_BIT (IDLE_BIT),
    .LENW     (RW)
  ) u_piso (
    .clk      (clk),
    .clr      (clr),
    .load_en  (start),
    .shift_en (shift_en),
    .load_data(ld_word),
    .load_len (ld_len),
    .ser_out  (ser_out)
  );

  assign ser_valid  = ser_valid_q;
  assign word_done  = word_done_q;
  assign word_count = word_cnt_q;

endmodule

// File: tb/tb_serial_pattern_source.sv
// Bench for serial_pattern_source: MSB-first and LSB-first
// instances share stimulus and are checked against a bit-queue model.
module tb_serial_pattern_source;

  logic        clk = 1'b0;
  logic        clr;
  logic        load_valid;
  logic [7:0]  load_data;
  logic [4:0]  load_len;
  logic        repeat_en;

  logic        rdy_m, so_m, sv_m, wd_m;
  logic [15:0] wc_m;
  logic        rdy_l, so_l, sv_l, wd_l;
  logic [15:0] wc_l;

  always #5 clk = ~clk;

  serial_pattern_source #(
    .WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)
  ) dut_m (
    .clk(clk), .clr(clr),
    .load_valid(load_valid), .load_ready(rdy_m),
    .load_data(load_data), .load_len(load_len),
    .repeat_en(repeat_en),
    .ser_out(so_m), .ser_valid(sv_m),
    .word_done(wd_m), .word_count(wc_m)
  );

  serial_pattern_source #(
    .WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)
  ) dut_l (
    .clk(clk), .clr(clr),
    .load_valid(load_valid), .load_ready(rdy_l),
    .load_data(load_data), .load_len(load_len),
    .repeat_en(repeat_en),
    .ser_out(so_l), .ser_valid(sv_l),
    .word_done(wd_l), .word_count(wc_l)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model: the bits still to be presented, in wire order.
  bit          q_m[$];
  bit          q_l[$];
  logic [7:0]  hold_w;
  int          hold_n;
  logic [15:0] cnt_m;

  typedef struct {
    logic        clr;
    logic        lv;
    logic [7:0]  ld;
    logic [4:0]  ll;
    logic        rep;
    logic        e_so;
    logic        e_sv;
    logic        e_wd;
    logic [15:0] e_wc;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic int le(input int l);
    return (l == 0 || l > 8) ? 8 : l;
  endfunction

  task automatic fill(input logic [7:0] w, input int n);
    q_m.delete();
    q_l.delete();
    for (int i = n - 1; i >= 0; i--) q_m.push_back(w[i]);
    for (int i = 0; i < n; i++) q_l.push_back(w[i]);
    hold_w = w;
    hold_n = n;
  endtask

  // Check outputs against the model, advance it, move to next cycle.
  task automatic cycle();
    int sz;
    bit last;
    bit acc;
    bit e_m;
    bit e_l;
    sz  = q_m.size();
    e_m = 1'b0;
    e_l = 1'b0;
    if (sz > 0) begin
      e_m = q_m[0];
      e_l = q_l[0];
    end
    chk("ready_m", rdy_m, sz <= 1);
    chk("ready_l", rdy_l, sz <= 1);
    chk("ser_out_m", so_m, e_m);
    chk("ser_out_l", so_l, e_l);
    chk("ser_valid_m", sv_m, sz > 0);
    chk("ser_valid_l", sv_l, sz > 0);
    chk("word_done_m", wd_m, sz == 1);
    chk("word_done_l", wd_l, sz == 1);
    chk("word_count_m", wc_m, cnt_m);
    chk("word_count_l", wc_l, cnt_m);
    last = (sz == 1);
    acc  = load_valid && (sz <= 1);
    if (clr) begin
      q_m.delete();
      q_l.delete();
      cnt_m = '0;
    end else begin
      if (sz > 0) begin
        void'(q_m.pop_front());
        void'(q_l.pop_front());
      end
      if (acc) fill(load_data, le(int'(load_len)));
      else if (last && repeat_en) fill(hold_w, hold_n);
      if (last) cnt_m = cnt_m + 16'd1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic add(input logic c, input logic lv,
                     input logic [7:0] ld, input logic [4:0] ll,
                     input logic rep, input logic so,
                     input logic sv, input logic wd,
                     input logic [15:0] wc);
    vec_t v;
    v.clr = c;  v.lv = lv; v.ld = ld; v.ll = ll; v.rep = rep;
    v.e_so = so; v.e_sv = sv; v.e_wd = wd; v.e_wc = wc;
    tbl.push_back(v);
  endtask

  task automatic idle_in();
    clr        = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    load_len   = '0;
    repeat_en  = 1'b0;
  endtask

  logic [7:0] wb2;
  logic [2:0] w05;
  logic [15:0] c0;

  initial begin
    wb2 = 8'hB2;
    w05 = 3'b101;
    idle_in();
    clr = 1'b1;
    load_valid = 1'b1;
    load_data  = 8'hFF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    q_m.delete();
    q_l.delete();
    cnt_m  = '0;
    hold_w = '0;
    hold_n = 0;
    chk("rst_ser_out", so_m, 0);
    chk("rst_ser_valid", sv_m, 0);
    chk("rst_word_done", wd_m, 0);
    chk("rst_word_count", wc_m, 0);
    chk("rst_ready", rdy_m, 1);
    idle_in();

    // Single 0xB2 word, then a back-to-back 0xB2 + 0x05/len3.
    add(0, 1, 8'hB2, 5'd8, 0, 0, 0, 0, 16'd0);
    for (int i = 0; i < 8; i++)
      add(0, 0, 8'h00, 5'd0, 0, wb2[7-i], 1, i == 7, 16'd0);
    add(0, 0, 8'h00, 5'd0, 0, 0, 0, 0, 16'd1);
    add(0, 1, 8'hB2, 5'd8, 0, 0, 0, 0, 16'd1);
    for (int i = 0; i < 8; i++)
      add(0, 1, 8'h05, 5'd3, 0, wb2[7-i], 1, i == 7, 16'd1);
    for (int i = 0; i < 3; i++)
      add(0, 0, 8'h00, 5'd0, 0, w05[2-i], 1, i == 2, 16'd2);
    add(0, 0, 8'h00, 5'd0, 0, 0, 0, 0, 16'd3);

    for (int i = 0; i < tbl.size(); i++) begin
      clr        = tbl[i].clr;
      load_valid = tbl[i].lv;
      load_data  = tbl[i].ld;
      load_len   = tbl[i].ll;
      repeat_en  = tbl[i].rep;
      chk("tbl_ser_out", so_m, tbl[i].e_so);
      chk("tbl_ser_valid", sv_m, tbl[i].e_sv);
      chk("tbl_word_done", wd_m, tbl[i].e_wd);
      chk("tbl_word_count", wc_m, tbl[i].e_wc);
      cycle();
    end
    idle_in();

    // Repeat 0x05/len3 four times, dropping repeat_en mid 4th word.
    c0 = wc_m;
    load_valid = 1'b1; load_data = 8'h05; load_len = 5'd3;
    repeat_en = 1'b1;
    cycle();
    load_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (i == 10) repeat_en = 1'b0;
      chk("rep_bit", so_m, w05[2 - (i % 3)]);
      chk("rep_valid", sv_m, 1);
      cycle();
    end
    chk("rep_idle", sv_m, 0);
    chk("rep_count", wc_m, c0 + 16'd4);

    // Clear after three bits; a load offered with clr is dropped.
    load_valid = 1'b1; load_data = 8'hB2; load_len = 5'd8;
    cycle();
    load_valid = 1'b0;
    repeat (3) cycle();
    clr = 1'b1; load_valid = 1'b1; load_data = 8'hFF;
    cycle();
    idle_in();
    chk("clr_valid", sv_m, 0);
    chk("clr_ser_out", so_m, 0);
    chk("clr_count", wc_m, 0);
    chk("clr_done", wd_m, 0);
    repeat (2) cycle();

    // Length 0 and 12 both mean eight bits.
    for (int k = 0; k < 2; k++) begin
      load_valid = 1'b1; load_data = 8'hFF;
      load_len = (k == 0) ? 5'd0 : 5'd12;
      cycle();
      load_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
        chk("len_clamp_bit", so_m, 1);
        chk("len_clamp_valid", sv_m, 1);
        cycle();
      end
      chk("len_clamp_end", sv_m, 0);
    end

    // Length 1: bit and word_done coincide.
    load_valid = 1'b1; load_data = 8'h01; load_len = 5'd1;
    cycle();
    load_valid = 1'b0;
    chk("len1_bit", so_m, 1);
    chk("len1_done", wd_m, 1);
    chk("len1_ready", rdy_m, 1);
    cycle();
    chk("len1_end", sv_m, 0);

    // Length 1 streaming via repeat: done and ready every cycle.
    load_valid = 1'b1; load_data = 8'h01; load_len = 5'd1;
    repeat_en = 1'b1;
    cycle();
    load_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) repeat_en = 1'b0;
      chk("len1_rep_done", wd_m, 1);
      chk("len1_rep_ready", rdy_m, 1);
      chk("len1_rep_bit", so_l, 1);
      cycle();
    end
    chk("len1_rep_end", sv_m, 0);

    // LSB-first order of 0xB2.
    load_valid = 1'b1; load_data = 8'hB2; load_len = 5'd8;
    cycle();
    load_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("lsb_bit", so_l, wb2[i]);
      cycle();
    end

    // Counter wrap from 0xFFFF.
    force dut_m.word_cnt_q = 16'hFFFF;
    force dut_l.word_cnt_q = 16'hFFFF;
    #1;
    release dut_m.word_cnt_q;
    release dut_l.word_cnt_q;
    cnt_m = 16'hFFFF;
    load_valid = 1'b1; load_data = 8'h01; load_len = 5'd1;
    cycle();
    load_valid = 1'b0;
    cycle();
    chk("wrap_count", wc_m, 16'h0000);

    // Randomised traffic against the model.
    for (int i = 0; i < 600; i++) begin
      clr        = ($urandom_range(0, 49) == 0);
      load_valid = $urandom_range(0, 1) == 1;
      load_data  = 8'($urandom);
      load_len   = $urandom_range(0, 1) ?
                   5'($urandom_range(1, 4)) :
                   5'($urandom_range(0, 31));
      repeat_en  = ($urandom_range(0, 2) == 0);
      cycle();
    end
    idle_in();
    repeat (10) cycle();

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
